// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and size derivation for the scoreboarded register file
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_SP_INDEX = 2;
    localparam int DEF_SP_RESET = 256;

    function automatic int numRegs(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits; a set beats a clear on the same register
module reg_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                setEn,
    input  logic [ADDR_W-1:0]   setReg,
    input  logic                clrEn,
    input  logic [ADDR_W-1:0]   clrReg,
    output logic [NUM_REGS-1:0] pending,
    output logic [NUM_REGS-1:0] pendingNext,
    output logic                anyPending
);

    // Clear first, then set, so a new producer reserved on the writeback edge stays pending.
    always_comb begin
        pendingNext = pending;
        if (clrEn) begin
            pendingNext[clrReg] = 1'b0;
        end
        if (setEn) begin
            pendingNext[setReg] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    assign anyPending = |pending;

endmodule

// File: rtl/regfile_scoreboarded.sv
// rtl/regfile_scoreboarded.sv - N x W register file with two registered read ports and a pending scoreboard
module regfile_scoreboarded
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SP_INDEX = DEF_SP_INDEX,
    parameter int SP_RESET = DEF_SP_RESET,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              readEn,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeFile,
    input  logic              regWrite,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveReg,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              readPending1,
    output logic              readPending2,
    output logic              anyPending
);

    localparam int                NUM_REGS = numRegs(ADDR_W);
    localparam logic [DATA_W-1:0] SP_VALUE = DATA_W'(SP_RESET);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pendingNext;
    logic                writeOk;
    logic                reserveOk;
    logic [DATA_W-1:0]   rdNext1;
    logic [DATA_W-1:0]   rdNext2;
    logic                pnNext1;
    logic                pnNext2;

    // A hard-zero register swallows both writes and reservations.
    assign writeOk   = regWrite  && !(ZERO_REG && (writeReg == '0));
    assign reserveOk = reserveEn && !(ZERO_REG && (reserveReg == '0));

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .setEn       (reserveOk),
        .setReg      (reserveReg),
        .clrEn       (writeOk),
        .clrReg      (writeReg),
        .pending     (pending),
        .pendingNext (pendingNext),
        .anyPending  (anyPending)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_VALUE : '0;
            end
        end else if (writeOk) begin
            regs[writeReg] <= writeFile;
        end
    end

    // With BYPASS the captured values are what the register holds after this edge.
    always_comb begin
        rdNext1 = regs[readReg1];
        pnNext1 = pending[readReg1];
        rdNext2 = regs[readReg2];
        pnNext2 = pending[readReg2];
        if (BYPASS) begin
            if (writeOk && (writeReg == readReg1)) begin
                rdNext1 = writeFile;
            end
            if (writeOk && (writeReg == readReg2)) begin
                rdNext2 = writeFile;
            end
            pnNext1 = pendingNext[readReg1];
            pnNext2 = pendingNext[readReg2];
        end
        if (ZERO_REG && (readReg1 == '0)) begin
            rdNext1 = '0;
            pnNext1 = 1'b0;
        end
        if (ZERO_REG && (readReg2 == '0)) begin
            rdNext2 = '0;
            pnNext2 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readData1    <= '0;
            readData2    <= '0;
            readPending1 <= 1'b0;
            readPending2 <= 1'b0;
        end else if (readEn) begin
            readData1    <= rdNext1;
            readData2    <= rdNext2;
            readPending1 <= pnNext1;
            readPending2 <= pnNext2;
        end
    end

endmodule
